// File: rtl/ecc_pkg.sv
// Shared types and helpers for the SEC-DED scrubber.
// Holds the scrub FSM states and the check-bit width function.
package ecc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CHECK,
        ST_WR_REQ,
        ST_NEXT
    } scrub_state_e;

    // Smallest m with 2**m >= m + k + 1 (Hamming check bits for k data bits).
    function automatic int calculate_m(input int k);
        int m;
        m = 30;
        for (int i = 30; i >= 1; i--) begin
            if ((1 << i) >= (i + k + 1)) begin
                m = i;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_dec.sv
// SEC-DED Hamming decoder: syndrome plus single/double error flags.
// Overall parity bit p0 sits at the LSB or MSB of the codeword.
module ecc_dec
    import ecc_pkg::*;
#(
    parameter int K = 8,
    parameter int P0_LSB = 1,
    parameter int LATENCY = 0,
    localparam int M = calculate_m(K),
    localparam int N = M + K
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N:0]   cw_i,
    output logic [M-1:0] syndrome_o,
    output logic         sb_err_o,
    output logic         db_err_o
);

    logic [M-1:0] syn;
    logic         par;
    logic         sb_err;
    logic         db_err;

    // Syndrome is the XOR of the positions of all set Hamming bits.
    always_comb begin
        syn = '0;
        for (int p = 1; p <= N; p++) begin
            if (cw_i[(P0_LSB != 0) ? p : p - 1]) begin
                syn = syn ^ p[M-1:0];
            end
        end
        par    = ^cw_i;
        sb_err = par;
        db_err = !par && (syn != '0);
    end

    if (LATENCY == 0) begin : g_comb
        logic unused_clk;
        assign unused_clk = clk_i ^ rst_i;
        assign syndrome_o = syn;
        assign sb_err_o   = sb_err;
        assign db_err_o   = db_err;
    end else begin : g_reg
        logic [M-1:0] syndrome_q;
        logic         sb_err_q;
        logic         db_err_q;

        // One pipeline stage on the decoder results.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                syndrome_q <= '0;
                sb_err_q   <= 1'b0;
                db_err_q   <= 1'b0;
            end else begin
                syndrome_q <= syn;
                sb_err_q   <= sb_err;
                db_err_q   <= db_err;
            end
        end

        assign syndrome_o = syndrome_q;
        assign sb_err_o   = sb_err_q;
        assign db_err_o   = db_err_q;
    end

endmodule

// File: rtl/ecc_scrubber.sv
// Background memory scrubber: reads each word, corrects single-bit
// errors by write-back, counts and reports double-bit errors.
module ecc_scrubber
    import ecc_pkg::*;
#(
    parameter int K = 8,
    parameter int AW = 8,
    parameter int P0_LSB = 1,
    localparam int M = calculate_m(K),
    localparam int N = M + K
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [15:0]   interval_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic          mem_lock_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [N:0]    mem_wdata_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [N:0]    mem_rdata_i,
    output logic          busy_o,
    output logic          pass_done_o,
    output logic [15:0]   sb_cnt_o,
    output logic [15:0]   db_cnt_o,
    output logic [AW-1:0] db_addr_o,
    output logic          db_irq_o
);

    scrub_state_e  state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [N:0]    rdata_q, rdata_d;
    logic [N:0]    wdata_q, wdata_d;
    logic [15:0]   sb_cnt_q, sb_cnt_d;
    logic [15:0]   db_cnt_q, db_cnt_d;
    logic [AW-1:0] db_addr_q, db_addr_d;

    logic [M-1:0]  syndrome;
    logic          sb_err;
    logic          db_err;
    logic [N:0]    flip;

    ecc_dec #(
        .K       (K),
        .P0_LSB  (P0_LSB),
        .LATENCY (0)
    ) u_dec (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cw_i       (rdata_q),
        .syndrome_o (syndrome),
        .sb_err_o   (sb_err),
        .db_err_o   (db_err)
    );

    // One-hot mask of the codeword bit addressed by the syndrome.
    always_comb begin
        flip = '0;
        for (int i = 0; i <= N; i++) begin
            if (P0_LSB != 0) begin
                flip[i] = (int'(syndrome) == i);
            end else if (i == N) begin
                flip[i] = (syndrome == '0);
            end else begin
                flip[i] = (int'(syndrome) == i + 1);
            end
        end
    end

    // Next-state, datapath and output decode for the scrub sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        wdata_d     = wdata_q;
        sb_cnt_d    = sb_cnt_q;
        db_cnt_d    = db_cnt_q;
        db_addr_d   = db_addr_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_lock_o  = 1'b0;
        pass_done_o = 1'b0;
        db_irq_o    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = interval_i;
                end
            end
            ST_WAIT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_RD_REQ;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RD_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                mem_lock_o = 1'b1;
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                mem_lock_o = 1'b1;
                wdata_d    = rdata_q ^ flip;
                if (sb_err) begin
                    state_d = ST_WR_REQ;
                    if (sb_cnt_q != 16'hFFFF) begin
                        sb_cnt_d = sb_cnt_q + 16'd1;
                    end
                end else begin
                    state_d = ST_NEXT;
                end
                if (db_err) begin
                    db_irq_o  = 1'b1;
                    db_addr_d = addr_q;
                    if (db_cnt_q != 16'hFFFF) begin
                        db_cnt_d = db_cnt_q + 16'd1;
                    end
                end
            end
            ST_WR_REQ: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_lock_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                addr_d      = addr_q + AW'(1);
                pass_done_o = (addr_q == '1);
                if (en_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = interval_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear takes priority over any same-cycle increment.
        if (clr_i) begin
            sb_cnt_d  = '0;
            db_cnt_d  = '0;
            db_addr_d = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            sb_cnt_q  <= '0;
            db_cnt_q  <= '0;
            db_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            wdata_q   <= wdata_d;
            sb_cnt_q  <= sb_cnt_d;
            db_cnt_q  <= db_cnt_d;
            db_addr_q <= db_addr_d;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign sb_cnt_o    = sb_cnt_q;
    assign db_cnt_o    = db_cnt_q;
    assign db_addr_o   = db_addr_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed testbench for ecc_scrubber (K=8, AW=2, 13-bit codewords).
// A small memory responder grants requests and returns read data.
module tb_ecc_scrubber;

    localparam int AW = 2;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          clr_i;
    logic [15:0]   interval_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic          mem_lock_o;
    logic [AW-1:0] mem_addr_o;
    logic [CW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [CW-1:0] mem_rdata_i;
    logic          busy_o;
    logic          pass_done_o;
    logic [15:0]   sb_cnt_o;
    logic [15:0]   db_cnt_o;
    logic [AW-1:0] db_addr_o;
    logic          db_irq_o;

    ecc_scrubber #(
        .K      (8),
        .AW     (AW),
        .P0_LSB (1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .clr_i        (clr_i),
        .interval_i   (interval_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_lock_o   (mem_lock_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .pass_done_o  (pass_done_o),
        .sb_cnt_o     (sb_cnt_o),
        .db_cnt_o     (db_cnt_o),
        .db_addr_o    (db_addr_o),
        .db_irq_o     (db_irq_o)
    );

    always #5 clk = ~clk;

    // Hand-encoded clean codewords (p0 at bit 0, Hamming positions 1..12).
    localparam logic [CW-1:0] CW_A5 = 13'h144E;
    localparam logic [CW-1:0] CW_FF = 13'h1EEE;
    localparam logic [CW-1:0] CW_01 = 13'h000F;
    localparam logic [CW-1:0] CW_00 = 13'h0000;

    logic [CW-1:0] mem [4];
    logic [AW-1:0] raddr = '0;
    bit            pend = 1'b0;
    int            dly = 0;
    int            rv_delay = 1;
    bit            gnt_en = 1'b1;
    bit            block_wr = 1'b0;
    int            pd_cnt = 0;
    int            irq_cnt = 0;
    int            rd_target = 0;

    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] wr_addr_log[$];
    logic [CW-1:0] wr_data_log[$];
    bit            wr_lock_log[$];

    assign mem_gnt_i    = gnt_en && !(block_wr && mem_we_o);
    assign mem_rvalid_i = pend && (dly == 0);
    assign mem_rdata_i  = mem[raddr];

    always @(posedge clk) begin
        if (rst_i) begin
            pend <= 1'b0;
            dly  <= 0;
        end else begin
            if (pend) begin
                if (dly == 0) pend <= 1'b0;
                else dly <= dly - 1;
            end
            if (mem_req_o && mem_gnt_i && !mem_we_o) begin
                pend  <= 1'b1;
                dly   <= rv_delay - 1;
                raddr <= mem_addr_o;
                rd_log.push_back(mem_addr_o);
            end
            if (mem_req_o && mem_gnt_i && mem_we_o) begin
                wr_addr_log.push_back(mem_addr_o);
                wr_data_log.push_back(mem_wdata_o);
                wr_lock_log.push_back(mem_lock_o);
            end
            if (pass_done_o) pd_cnt <= pd_cnt + 1;
            if (db_irq_o) irq_cnt <= irq_cnt + 1;
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return pass_done_o;
            1: return !busy_o;
            2: return mem_lock_o;
            3: return mem_req_o && mem_we_o;
            4: return rd_log.size() > rd_target;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cond(sel)) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        rst_i      = 1'b1;
        en_i       = 1'b0;
        clr_i      = 1'b0;
        interval_i = 16'd0;
        mem[0] = CW_A5;
        mem[1] = CW_FF;
        mem[2] = CW_01;
        mem[3] = CW_00;
        repeat (2) @(negedge clk);

        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_lock", 32'(mem_lock_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_sb", 32'(sb_cnt_o), 32'd0);
        chk("rst_db", 32'(db_cnt_o), 32'd0);
        chk("rst_dbaddr", 32'(db_addr_o), 32'd0);
        chk("rst_pulses", 32'({pass_done_o, db_irq_o}), 32'd0);
        rst_i = 1'b0;

        // Clean pass with zero interval.
        en_i = 1'b1;
        wait_for(0, 200, "p1_pass_done");
        en_i = 1'b0;
        wait_for(1, 20, "p1_idle");
        chk("p1_reads", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("p1_rd_addr%0d", i), 32'(rd_log[i]), 32'(i));
        end
        chk("p1_writes", 32'(wr_addr_log.size()), 32'd0);
        chk("p1_sb", 32'(sb_cnt_o), 32'd0);
        chk("p1_db", 32'(db_cnt_o), 32'd0);
        chk("p1_pd_cnt", 32'(pd_cnt), 32'd1);
        chk("p1_addr_wrap", 32'(mem_addr_o), 32'd0);

        // Pass with single, p0-only and double errors, interval 2.
        mem[1] = CW_FF ^ 13'h0020;
        mem[2] = CW_01 ^ 13'h0001;
        mem[3] = CW_00 ^ 13'h0048;
        interval_i = 16'd2;
        en_i = 1'b1;
        wait_for(0, 400, "p2_pass_done");
        en_i = 1'b0;
        wait_for(1, 20, "p2_idle");
        chk("p2_writes", 32'(wr_addr_log.size()), 32'd2);
        chk("p2_wr0_addr", 32'(wr_addr_log[0]), 32'd1);
        chk("p2_wr0_data", 32'(wr_data_log[0]), 32'(CW_FF));
        chk("p2_wr0_lock", 32'(wr_lock_log[0]), 32'd1);
        chk("p2_wr1_addr", 32'(wr_addr_log[1]), 32'd2);
        chk("p2_wr1_data", 32'(wr_data_log[1]), 32'(CW_01));
        chk("p2_sb", 32'(sb_cnt_o), 32'd2);
        chk("p2_db", 32'(db_cnt_o), 32'd1);
        chk("p2_db_addr", 32'(db_addr_o), 32'd3);
        chk("p2_irq_cnt", 32'(irq_cnt), 32'd1);
        chk("p2_pd_cnt", 32'(pd_cnt), 32'd2);

        // Counter clear.
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        chk("clr_sb", 32'(sb_cnt_o), 32'd0);
        chk("clr_db", 32'(db_cnt_o), 32'd0);
        chk("clr_db_addr", 32'(db_addr_o), 32'd0);

        // Enable dropped during a slow read.
        mem[1] = CW_FF;
        mem[2] = CW_01;
        mem[3] = CW_00;
        interval_i = 16'd0;
        rv_delay = 5;
        en_i = 1'b1;
        wait_for(2, 50, "p3_in_rd_wait");
        en_i = 1'b0;
        chk("p3_no_rvalid_yet", 32'(mem_rvalid_i), 32'd0);
        wait_for(1, 30, "p3_idle");
        chk("p3_reads", 32'(rd_log.size()), 32'd9);
        chk("p3_rd_addr", 32'(rd_log[8]), 32'd0);
        chk("p3_next_addr", 32'(mem_addr_o), 32'd1);
        en_i = 1'b1;
        rd_target = 9;
        wait_for(4, 50, "p3_resume_read");
        en_i = 1'b0;
        chk("p3_resume_addr", 32'(rd_log[9]), 32'd1);
        wait_for(1, 30, "p3_idle2");
        chk("p3_addr_after", 32'(mem_addr_o), 32'd2);
        chk("p3_writes", 32'(wr_addr_log.size()), 32'd2);

        // Reset while a write-back is stalled.
        rv_delay = 1;
        mem[2] = CW_01 ^ 13'h0080;
        block_wr = 1'b1;
        en_i = 1'b1;
        wait_for(3, 50, "p4_in_wr_req");
        chk("p4_sb_before", 32'(sb_cnt_o), 32'd1);
        chk("p4_lock_wr", 32'(mem_lock_o), 32'd1);
        rst_i = 1'b1;
        en_i = 1'b0;
        @(negedge clk);
        chk("p4_req", 32'(mem_req_o), 32'd0);
        chk("p4_busy", 32'(busy_o), 32'd0);
        chk("p4_sb", 32'(sb_cnt_o), 32'd0);
        chk("p4_db", 32'(db_cnt_o), 32'd0);
        chk("p4_addr", 32'(mem_addr_o), 32'd0);
        rst_i = 1'b0;
        block_wr = 1'b0;
        repeat (5) @(negedge clk);
        chk("p4_no_write", 32'(wr_addr_log.size()), 32'd2);
        chk("p4_idle_req", 32'({busy_o, mem_req_o}), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ecc_scrubber.md
ECC_SCRUBBER -- requirements
Module: ecc_scrubber

Interface
REQ-001 Parameter K, default 8: information bits per word.
REQ-002 Parameter AW, default 8: memory address width; scrubbed range is 0 to 2**AW-1.
REQ-003 Parameter P0_LSB, default 1: overall parity bit p0 at codeword LSB (1) or MSB (0).
REQ-004 Derived widths: m = smallest m with 2**m >= m+K+1; n = m+K; codeword width is n+1.
REQ-005 Ports, in this order:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- en_i  in  1  scrub enable.
- clr_i  in  1  clear counters and double-error capture.
- interval_i  in  16  idle cycles between scrub operations.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write-back, 0 = read.
- mem_lock_o  out  1  holds memory against other writers during read-modify-write.
- mem_addr_o  out  AW  request address.
- mem_wdata_o  out  n+1  corrected codeword.
- mem_gnt_i  in  1  request accepted when mem_req_o & mem_gnt_i.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  n+1  read codeword.
- busy_o  out  1  state is not IDLE.
- pass_done_o  out  1  one-cycle pulse at address wrap.
- sb_cnt_o  out  16  corrected single-bit errors, saturating.
- db_cnt_o  out  16  detected double-bit errors, saturating.
- db_addr_o  out  AW  address of the most recent double error.
- db_irq_o  out  1  one-cycle pulse per double error.

Function
REQ-006 FSM states: IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
REQ-007 IDLE->WAIT when en_i=1; WAIT loads a down-counter with interval_i and advances to RD_REQ when it reaches 0; interval_i=0 means WAIT lasts exactly 1 cycle.
REQ-008 RD_REQ: mem_req_o=1, mem_we_o=0, mem_addr_o=current address; stays until mem_gnt_i, then goes to RD_WAIT.
REQ-009 mem_lock_o is 1 from the cycle after the read grant until leaving CHECK (no write needed) or until the WR_REQ grant.
REQ-010 RD_WAIT: on mem_rvalid_i, capture mem_rdata_i into a register and go to CHECK; mem_rvalid_i in any other state is ignored.
REQ-011 CHECK (1 cycle): classify the registered word with the combinational decoder:
- parity odd = single error; go to WR_REQ.
- parity even with nonzero syndrome = double error; go to NEXT with no write.
- otherwise clean; go to NEXT.
REQ-012 Corrected word = captured word with the bit at position syndrome inverted, in P0_LSB-adjusted position; syndrome 0 with odd parity inverts p0.
REQ-013 WR_REQ: mem_req_o=1, mem_we_o=1, same address, mem_wdata_o = corrected word registered in CHECK; stays until mem_gnt_i, then goes to NEXT.
REQ-014 A single error increments sb_cnt_o in CHECK.
REQ-015 A double error increments db_cnt_o, loads db_addr_o and pulses db_irq_o, all in CHECK.
REQ-016 Counters saturate at 16'hFFFF.
REQ-017 NEXT: address increments; 2**AW-1 wraps to 0 with pass_done_o=1 that cycle; then WAIT if en_i=1, else IDLE.
REQ-018 en_i=0 outside IDLE/WAIT never aborts: the current address completes, including any outstanding read and required write-back; en_i=0 in WAIT goes to IDLE.
REQ-019 The address is retained across IDLE, so scrubbing resumes where it stopped.
REQ-020 clr_i zeroes sb_cnt_o, db_cnt_o and db_addr_o; if clr_i coincides with an increment, clr_i wins.
REQ-021 mem_req_o is never asserted outside RD_REQ and WR_REQ; at most one request is outstanding.

Reset
REQ-022 rst_i=1 at a clock edge sets: state IDLE, address 0, all counters and registers 0, all outputs 0; this applies in any state, including mid-transaction.
REQ-023 After reset, late mem_rvalid_i or mem_gnt_i arriving in IDLE is ignored.

Structure
REQ-024 Package ecc_pkg holds the FSM state enum and the calculate_m function shared with the encoder and decoder.
REQ-025 One sub-module: ecc_dec, instantiated with LATENCY=0 and the same K and P0_LSB, fed from the captured-word register; syndrome and flag outputs are used directly.
REQ-026 Codeword correction (REQ-012) is done locally, not in a separate module.

Verification (K=8, AW=2, P0_LSB=1, 13-bit codeword)
REQ-027 Clean memory, interval_i=0, gnt tied 1, rvalid 1 cycle after grant -> 4 reads, no writes, pass_done_o pulses after address 3, counters stay 0.
REQ-028 Address 1 has bit 5 flipped -> write to address 1 with the bit restored, sb_cnt_o=1.
REQ-029 Address 2 has only p0 flipped -> write-back with p0 restored, sb_cnt_o=1.
REQ-030 Address 3 has bits 3 and 6 flipped -> no write, db_cnt_o=1, db_addr_o=3, one db_irq_o pulse.
REQ-031 en_i dropped while in RD_WAIT with rvalid delayed 5 cycles -> read completes, state goes to IDLE, next enable resumes at the following address.
REQ-032 rst_i asserted in WR_REQ with gnt held 0 -> next cycle mem_req_o=0, busy_o=0, counters 0; mem_gnt_i=1 after reset causes no write.
